// File: rtl/leitor_matriz.sv
// Read-side streamer: captures a packed DIM x DIM signed matrix on start and
// emits it one element per valid/ready handshake, row-major or column-major.
module leitor_matriz #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5,
    parameter int IDX_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      col_major,
    input  logic [DIM*DIM*DATA_W-1:0] matriz_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_row,
    output logic [IDX_W-1:0]          out_col,
    output logic                      out_last,
    output logic                      done
);

    localparam int MAT_W = DIM * DIM * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_t;

    state_t               state_q, state_d;
    logic [MAT_W-1:0]     mat_q, mat_d;
    logic                 colMajor_q, colMajor_d;
    logic [IDX_W-1:0]     row_q, row_d;
    logic [IDX_W-1:0]     col_q, col_d;
    logic [IDX_W-1:0]     advRow, advCol;
    logic                 isLast;
    logic                 handshake;
    logic [DATA_W-1:0]    grid [DIM][DIM];

    for (genvar r = 0; r < DIM; r++) begin : gRow
        for (genvar c = 0; c < DIM; c++) begin : gCol
            assign grid[r][c] = mat_q[(r*DIM+c)*DATA_W +: DATA_W];
        end
    end

    assign isLast    = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign handshake = (state_q == STREAM) && out_ready;

    assign busy      = (state_q == STREAM);
    assign out_valid = (state_q == STREAM);
    assign out_last  = (state_q == STREAM) && isLast;
    assign done      = (state_q == FIN);
    assign out_data  = grid[row_q][col_q];
    assign out_row   = row_q;
    assign out_col   = col_q;

    // Nested wrap counters: the inner index is col in row-major order and
    // row in column-major order; the final wrap lands back on (0,0).
    always_comb begin
        advRow = row_q;
        advCol = col_q;
        if (!colMajor_q) begin
            if (col_q == LAST_IDX) begin
                advCol = '0;
                advRow = (row_q == LAST_IDX) ? '0 : row_q + IDX_W'(1);
            end else begin
                advCol = col_q + IDX_W'(1);
            end
        end else begin
            if (row_q == LAST_IDX) begin
                advRow = '0;
                advCol = (col_q == LAST_IDX) ? '0 : col_q + IDX_W'(1);
            end else begin
                advRow = row_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mat_d      = mat_q;
        colMajor_d = colMajor_q;
        row_d      = row_q;
        col_d      = col_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = STREAM;
                    mat_d      = matriz_in;
                    colMajor_d = col_major;
                    row_d      = '0;
                    col_d      = '0;
                end
            end
            STREAM: begin
                if (handshake) begin
                    row_d = advRow;
                    col_d = advCol;
                    if (isLast) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mat_q      <= '0;
            colMajor_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            mat_q      <= mat_d;
            colMajor_q <= colMajor_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

endmodule

// File: tb/tb_leitor_matriz.sv
// Directed bench for leitor_matriz: expected beats come from closed-form
// element formulas and beat-to-(row,col) mapping computed here.
module tb_leitor_matriz;

    localparam int DATA_W = 8;
    localparam int DIM    = 5;
    localparam int IDX_W  = 3;
    localparam int MAT_W  = DIM * DIM * DATA_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 col_major;
    logic                 out_ready;
    logic [MAT_W-1:0]     matriz_in;
    logic                 busy;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic [IDX_W-1:0]     out_row;
    logic [IDX_W-1:0]     out_col;
    logic                 out_last;
    logic                 done;

    int nCompared   = 0;
    int nMismatched = 0;

    leitor_matriz #(.DATA_W(DATA_W), .DIM(DIM), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_major (col_major),
        .matriz_in (matriz_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    wire [17:0] obs = {busy, out_valid, out_data, out_row, out_col, out_last, done};
    wire [3:0]  ctl = {busy, out_valid, out_last, done};

    // kind 0: -(r*5+c+1), kind 1: r*5+c, kind 2: 127/-128 alternating by flat index
    function automatic logic [7:0] elemOf(int kind, int r, int c);
        int idx;
        idx = r * DIM + c;
        case (kind)
            0:       return 8'(-(idx + 1));
            1:       return 8'(idx);
            default: return (idx % 2 == 0) ? 8'h7F : 8'h80;
        endcase
    endfunction

    function automatic logic [MAT_W-1:0] buildMat(int kind);
        logic [MAT_W-1:0] m;
        m = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[(r*DIM+c)*DATA_W +: DATA_W] = elemOf(kind, r, c);
        return m;
    endfunction

    function automatic logic [17:0] expBeat(int kind, logic cm, int k);
        int r;
        int c;
        r = cm ? (k % DIM) : (k / DIM);
        c = cm ? (k / DIM) : (k % DIM);
        return {1'b1, 1'b1, elemOf(kind, r, c), 3'(r), 3'(c), (k == DIM*DIM-1), 1'b0};
    endfunction

    task automatic startStream(int kind, logic cm);
        matriz_in = buildMat(kind);
        col_major = cm;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        col_major = ~cm;
        matriz_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        nCompared++;
        if (obs !== 18'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_async: got %h want %h", obs, 18'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if (obs !== 18'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_held: got %h want %h", obs, 18'h0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_row_major();
        out_ready = 1'b1;
        startStream(0, 1'b0);
        for (int k = 0; k < DIM*DIM; k++) begin
            nCompared++;
            if (obs !== expBeat(0, 1'b0, k)) begin
                nMismatched++;
                $display("[TB] FAIL row_major beat %0d: got %h want %h", k, obs, expBeat(0, 1'b0, k));
            end
            @(posedge clk); #1;
        end
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL row_major done: got %b want %b", ctl, 4'b0001);
        end
        @(posedge clk); #1;
        nCompared++;
        if (ctl !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL row_major idle: got %b want %b", ctl, 4'b0000);
        end
    endtask

    task automatic test_col_major();
        out_ready = 1'b1;
        startStream(0, 1'b1);
        for (int k = 0; k < DIM*DIM; k++) begin
            nCompared++;
            if (obs !== expBeat(0, 1'b1, k)) begin
                nMismatched++;
                $display("[TB] FAIL col_major beat %0d: got %h want %h", k, obs, expBeat(0, 1'b1, k));
            end
            @(posedge clk); #1;
        end
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL col_major done: got %b want %b", ctl, 4'b0001);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        int k;
        int cyc;
        pat = 6'b101001;
        k   = 0;
        cyc = 0;
        startStream(0, 1'b0);
        while (k < DIM*DIM && cyc < 200) begin
            out_ready = pat[cyc % 6];
            nCompared++;
            if (obs !== expBeat(0, 1'b0, k)) begin
                nMismatched++;
                $display("[TB] FAIL backpressure cyc %0d beat %0d: got %h want %h", cyc, k, obs, expBeat(0, 1'b0, k));
            end
            if (out_ready) k++;
            cyc++;
            @(posedge clk); #1;
        end
        nCompared++;
        if (k != DIM*DIM) begin
            nMismatched++;
            $display("[TB] FAIL backpressure timeout: got %0d beats want %0d", k, DIM*DIM);
        end
        out_ready = 1'b1;
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL backpressure done: got %b want %b", ctl, 4'b0001);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        out_ready = 1'b1;
        startStream(0, 1'b0);
        for (int k = 0; k < DIM*DIM; k++) begin
            if (k == 7) begin
                start     = 1'b1;
                col_major = 1'b1;
                matriz_in = '0;
            end
            nCompared++;
            if (obs !== expBeat(0, 1'b0, k)) begin
                nMismatched++;
                $display("[TB] FAIL ignored_start beat %0d: got %h want %h", k, obs, expBeat(0, 1'b0, k));
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL ignored_start done: got %b want %b", ctl, 4'b0001);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        startStream(0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            nCompared++;
            if (obs !== expBeat(0, 1'b0, k)) begin
                nMismatched++;
                $display("[TB] FAIL mid_reset pre beat %0d: got %h want %h", k, obs, expBeat(0, 1'b0, k));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        nCompared++;
        if (obs !== 18'h0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset abort: got %h want %h", obs, 18'h0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        startStream(1, 1'b0);
        for (int k = 0; k < DIM*DIM; k++) begin
            nCompared++;
            if (obs !== expBeat(1, 1'b0, k)) begin
                nMismatched++;
                $display("[TB] FAIL mid_reset restream beat %0d: got %h want %h", k, obs, expBeat(1, 1'b0, k));
            end
            @(posedge clk); #1;
        end
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset done: got %b want %b", ctl, 4'b0001);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        startStream(2, 1'b0);
        for (int k = 0; k < DIM*DIM; k++) begin
            nCompared++;
            if (obs !== expBeat(2, 1'b0, k)) begin
                nMismatched++;
                $display("[TB] FAIL extremes beat %0d: got %h want %h", k, obs, expBeat(2, 1'b0, k));
            end
            @(posedge clk); #1;
        end
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL extremes done: got %b want %b", ctl, 4'b0001);
        end
        // A start seen while in FIN must not launch a stream.
        matriz_in = buildMat(0);
        col_major = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        nCompared++;
        if (ctl !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL fin_start_ignored: got %b want %b", ctl, 4'b0000);
        end
        startStream(2, 1'b1);
        for (int k = 0; k < DIM*DIM; k++) begin
            nCompared++;
            if (obs !== expBeat(2, 1'b1, k)) begin
                nMismatched++;
                $display("[TB] FAIL back_to_back beat %0d: got %h want %h", k, obs, expBeat(2, 1'b1, k));
            end
            @(posedge clk); #1;
        end
        nCompared++;
        if (ctl !== 4'b0001) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back done: got %b want %b", ctl, 4'b0001);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        col_major = 1'b0;
        out_ready = 1'b0;
        matriz_in = '0;
        test_reset();
        test_row_major();
        test_col_major();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_stream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
